// File: rtl/awg_fifo_wr_arbiter.sv
// Four-channel round-robin write arbiter that feeds the AWG sample async FIFO write port.
// Grants one source per burst of up to P_BURST beats and prefixes each word with its channel ID.
module awg_fifo_wr_arbiter #(
  parameter int unsigned P_DATA_WIDE = 8,
  parameter int unsigned P_BURST     = 4
) (
  input  logic                     wr_clk,
  input  logic                     rst,
  input  logic [3:0]               cfg_en_mask_i,
  input  logic [3:0]               s_valid_i,
  input  logic [4*P_DATA_WIDE-1:0] s_data_i,
  output logic [3:0]               s_ready_o,
  output logic                     fifo_wr_en_o,
  output logic [P_DATA_WIDE+1:0]   fifo_wr_din_o,
  input  logic                     fifo_full_i,
  input  logic                     fifo_almost_full_i,
  output logic [1:0]               grant_ch_o,
  output logic                     busy_o
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  localparam logic [4:0] LastBeat = 5'(P_BURST - 1);

  state_e     state_q, state_d;
  logic [1:0] grant_ch_q, grant_ch_d;
  logic [1:0] last_ch_q, last_ch_d;
  logic [4:0] beat_cnt_q, beat_cnt_d;

  logic [3:0] req;
  logic       req_found;
  logic [1:0] req_ch;
  logic [1:0] cand;
  logic       grant_valid;
  logic       accept;

  // Search order starts one past the last granted channel, wrapping mod 4.
  always_comb begin
    req       = s_valid_i & cfg_en_mask_i;
    req_found = 1'b0;
    req_ch    = last_ch_q;
    cand      = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ch_q + 2'(i);
      if (!req_found && req[cand]) begin
        req_found = 1'b1;
        req_ch    = cand;
      end
    end
  end

  assign grant_valid   = s_valid_i[grant_ch_q];
  assign fifo_wr_din_o = {grant_ch_q, s_data_i[grant_ch_q*P_DATA_WIDE +: P_DATA_WIDE]};
  assign grant_ch_o    = grant_ch_q;
  assign busy_o        = (state_q == StBurst);

  always_comb begin
    state_d      = state_q;
    grant_ch_d   = grant_ch_q;
    last_ch_d    = last_ch_q;
    beat_cnt_d   = beat_cnt_q;
    s_ready_o    = '0;
    fifo_wr_en_o = 1'b0;
    accept       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_found && !fifo_almost_full_i) begin
          grant_ch_d = req_ch;
          last_ch_d  = req_ch;
          beat_cnt_d = '0;
          state_d    = StBurst;
        end
      end
      StBurst: begin
        // fifo_full gates acceptance combinationally so no beat is offered to a full FIFO.
        s_ready_o[grant_ch_q] = !fifo_full_i;
        accept                = grant_valid && !fifo_full_i;
        fifo_wr_en_o          = accept;
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
        end
        if ((accept && (beat_cnt_q == LastBeat)) || !grant_valid || fifo_almost_full_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_ch_q <= 2'd0;
      last_ch_q  <= 2'd3;
      beat_cnt_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      grant_ch_q <= grant_ch_d;
      last_ch_q  <= last_ch_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_awg_fifo_wr_arbiter.sv
// Bench for awg_fifo_wr_arbiter: directed vector table, hand sequences for multi-cycle corners,
// and random traffic checked against a burst-level reference model and per-channel scoreboards.
module tb_awg_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic          wr_clk;
  logic          rst;
  logic [3:0]    cfg_en_mask;
  logic [3:0]    s_valid;
  logic [4*DW-1:0] s_data;
  logic [3:0]    s_ready;
  logic          fifo_wr_en;
  logic [DW+1:0] fifo_wr_din;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic [1:0]    grant_ch;
  logic          busy;

  awg_fifo_wr_arbiter #(
    .P_DATA_WIDE(DW),
    .P_BURST    (BURST)
  ) dut (
    .wr_clk            (wr_clk),
    .rst               (rst),
    .cfg_en_mask_i     (cfg_en_mask),
    .s_valid_i         (s_valid),
    .s_data_i          (s_data),
    .s_ready_o         (s_ready),
    .fifo_wr_en_o      (fifo_wr_en),
    .fifo_wr_din_o     (fifo_wr_din),
    .fifo_full_i       (fifo_full),
    .fifo_almost_full_i(fifo_almost_full),
    .grant_ch_o        (grant_ch),
    .busy_o            (busy)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: burst in progress, granted channel, beats written, last channel granted.
  bit m_burst = 1'b0;
  int m_ch    = 0;
  int m_beats = 0;
  int m_last  = 3;

  logic [7:0] src_cnt[4];
  logic [7:0] exp_cnt[4];

  logic [3:0] smp_ready;
  logic       smp_wr;
  logic       smp_busy;
  logic [1:0] smp_grant;

  typedef struct {
    logic [3:0] v;
    logic       f;
    logic       af;
    logic [3:0] ready;
    logic       wr;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] data_of(input int ch, input logic [7:0] cnt);
    return cnt ^ {2'(ch), 6'b0};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic f, input logic af,
                              input logic [3:0] ready, input logic wr, input logic bsy);
    vec_t t;
    t.v = v; t.f = f; t.af = af; t.ready = ready; t.wr = wr; t.busy = bsy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, compare against model at negedge, then advance model.
  task automatic cyc(input logic r, input logic [3:0] m, input logic [3:0] v,
                     input logic f, input logic af);
    logic [3:0] e_ready;
    logic       e_wr;
    logic [3:0] req;
    logic [1:0] id;
    bit         found;
    rst = r; cfg_en_mask = m; s_valid = v; fifo_full = f; fifo_almost_full = af;
    for (int c = 0; c < 4; c++) s_data[c*DW +: DW] = data_of(c, src_cnt[c]);
    @(negedge wr_clk);
    e_ready = (m_burst && !f) ? (4'b0001 << m_ch) : 4'b0000;
    e_wr    = m_burst && v[m_ch] && !f;
    chk("s_ready", 32'(s_ready), 32'(e_ready));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    chk("busy", 32'(busy), 32'(m_burst));
    chk("grant_ch", 32'(grant_ch), 32'(m_ch));
    if (e_wr) chk("fifo_wr_din", 32'(fifo_wr_din), {22'd0, 2'(m_ch), data_of(m_ch, src_cnt[m_ch])});
    if (fifo_wr_en) begin
      id = fifo_wr_din[DW+1:DW];
      chk("scoreboard", 32'(fifo_wr_din[DW-1:0]), 32'(data_of(int'(id), exp_cnt[id])));
      exp_cnt[id] = exp_cnt[id] + 8'd1;
    end
    if (f) chk("no_write_when_full", 32'(fifo_wr_en), 32'd0);
    smp_ready = s_ready; smp_wr = fifo_wr_en; smp_busy = busy; smp_grant = grant_ch;
    for (int c = 0; c < 4; c++) if (v[c] && s_ready[c]) src_cnt[c] = src_cnt[c] + 8'd1;
    if (r) begin
      m_burst = 1'b0; m_ch = 0; m_beats = 0; m_last = 3;
    end else if (!m_burst) begin
      req   = v & m;
      found = 1'b0;
      if (req != 4'b0 && !af) begin
        for (int k = 1; k <= 4; k++) begin
          if (!found && req[(m_last + k) % 4]) begin
            found = 1'b1;
            m_ch  = (m_last + k) % 4;
          end
        end
        m_last  = m_ch;
        m_beats = 0;
        m_burst = 1'b1;
      end
    end else begin
      if (e_wr) m_beats++;
      if ((e_wr && m_beats == BURST) || !v[m_ch] || af) m_burst = 1'b0;
    end
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    int   g[$];
    int   w[8];
    int   nb;
    logic pb;
    logic [3:0] ready_or;

    for (int c = 0; c < 4; c++) begin
      src_cnt[c] = 8'd0;
      exp_cnt[c] = 8'd0;
    end
    rst = 1'b1; cfg_en_mask = 4'h0; s_valid = 4'h0; s_data = '0;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;

    // Single ch0: two full bursts, full stall after beat 2, almost_full during beat 1.
    tbl.push_back(mk(4'h1, 0, 0, 4'h0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(4'h1, 0, 0, 4'h1, 1, 1));
    tbl.push_back(mk(4'h1, 0, 0, 4'h0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(4'h1, 0, 0, 4'h1, 1, 1));
    tbl.push_back(mk(4'h1, 0, 0, 4'h0, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'h1, 0, 0, 4'h1, 1, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'h1, 1, 0, 4'h0, 0, 1));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'h1, 0, 0, 4'h1, 1, 1));
    tbl.push_back(mk(4'h1, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(4'h1, 0, 1, 4'h1, 1, 1));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'h1, 0, 1, 4'h0, 0, 0));
    tbl.push_back(mk(4'h1, 0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(4'h1, 0, 0, 4'h1, 1, 1));
    tbl.push_back(mk(4'h0, 0, 0, 4'h1, 0, 1));
    tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0));

    foreach (tbl[i]) begin
      cyc(1'b0, 4'hF, tbl[i].v, tbl[i].f, tbl[i].af);
      chk($sformatf("tbl[%0d].ready", i), 32'(smp_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl[%0d].wr_en", i), 32'(smp_wr), 32'(tbl[i].wr));
      chk($sformatf("tbl[%0d].busy", i), 32'(smp_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl[%0d].grant", i), 32'(smp_grant), 32'd0);
    end

    // All four channels valid from reset: grant order 0,1,2,3,0 with 4 beats each.
    cyc(1'b1, 4'hF, 4'h0, 0, 0);
    cyc(1'b1, 4'hF, 4'h0, 0, 0);
    nb = -1; pb = 1'b0;
    for (int i = 0; i < 8; i++) w[i] = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, 4'hF, 4'hF, 0, 0);
      if (smp_busy && !pb) begin
        g.push_back(int'(smp_grant));
        nb++;
      end
      if (smp_wr && nb >= 0 && nb < 8) w[nb]++;
      pb = smp_busy;
    end
    chk("rr_grant_count", 32'(g.size()), 32'd5);
    for (int i = 0; i < 5; i++) if (i < g.size()) chk("rr_order", 32'(g[i]), 32'(i % 4));
    for (int i = 0; i < 4; i++) chk("rr_beats", 32'(w[i]), 32'(BURST));

    // Mask 4'b1010: only ch1 and ch3, alternating (last grant was ch0).
    g.delete();
    pb = smp_busy;
    ready_or = 4'h0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 4'b1010, 4'hF, 0, 0);
      ready_or = ready_or | smp_ready;
      if (smp_busy && !pb) g.push_back(int'(smp_grant));
      pb = smp_busy;
    end
    chk("mask_blocked_ready", 32'(ready_or & 4'b0101), 32'd0);
    chk("mask_grant_count", 32'(g.size() >= 3), 32'd1);
    foreach (g[i]) chk("mask_grant", 32'(g[i]), (i % 2 == 0) ? 32'd1 : 32'd3);

    // Reset during beat 2 of a ch2 burst.
    cyc(1'b1, 4'hF, 4'h0, 0, 0);
    cyc(1'b1, 4'hF, 4'h0, 0, 0);
    cyc(1'b0, 4'hF, 4'b0100, 0, 0);
    cyc(1'b0, 4'hF, 4'b0100, 0, 0);
    chk("rstmid_beat1_grant", 32'(smp_grant), 32'd2);
    chk("rstmid_beat1_wr", 32'(smp_wr), 32'd1);
    cyc(1'b1, 4'hF, 4'b0100, 0, 0);
    cyc(1'b0, 4'hF, 4'b0110, 0, 0);
    chk("rstmid_after_wr", 32'(smp_wr), 32'd0);
    chk("rstmid_after_busy", 32'(smp_busy), 32'd0);
    cyc(1'b0, 4'hF, 4'b0110, 0, 0);
    chk("rstmid_regrant_busy", 32'(smp_busy), 32'd1);
    chk("rstmid_regrant_ch", 32'(smp_grant), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(63) == 0,
          ($urandom_range(1) == 0) ? 4'hF : 4'($urandom_range(15)),
          4'($urandom | $urandom),
          $urandom_range(7) == 0,
          $urandom_range(7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/awg_fifo_wr_arbiter.md
# awg_fifo_wr_arbiter

Four-channel round-robin write arbiter that shares the single write port of the AWG sample async FIFO among four sample sources in the wr_clk domain. It grants one source at a time for a bounded burst and tags each word with its 2-bit channel ID. It throttles on the FIFO's full and almost_full flags so no accepted word is ever dropped. It sits directly in front of the FIFO write port, and the FIFO is instantiated with data width P_DATA_WIDE+2.

## Interface
- P_DATA_WIDE, 8, sample width per source.
- P_BURST, 4, maximum beats per grant; legal range 1..16.
- wr_clk  in  1  write-domain clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- cfg_en_mask  in  4  per-channel arbitration enable; bit i=0 means channel i is never granted.
- s_valid  in  4  per-channel word valid.
- s_data  in  4*P_DATA_WIDE  channel i occupies bits [i*P_DATA_WIDE +: P_DATA_WIDE].
- s_ready  out  4  per-channel accept; a word transfers when s_valid[i]&&s_ready[i].
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_wr_din  out  P_DATA_WIDE+2  {grant_ch, s_data[grant_ch]}, channel ID in the MSBs.
- fifo_full  in  1  from FIFO full.
- fifo_almost_full  in  1  from FIFO almost_full.
- grant_ch  out  2  currently or last granted channel.
- busy  out  1  high while in BURST.

## Operation
- There are two states, IDLE and BURST, with registers state, grant_ch, beat_cnt (5 bits) and last_ch (2 bits).
- Reset values: state=IDLE, grant_ch=0, beat_cnt=0, last_ch=3. On the next cycle, s_ready=0, fifo_wr_en=0 and busy=0.
- **IDLE:**
  - Form the request vector req = s_valid & cfg_en_mask.
  - If req≠0 and fifo_almost_full=0, select the first set bit of req searching last_ch+1, last_ch+2, ... mod 4.
  - Load grant_ch and last_ch with the selected channel, clear beat_cnt, and go to BURST.
  - Otherwise stay in IDLE.
  - s_ready=0 and fifo_wr_en=0 throughout IDLE.
- **BURST:**
  - s_ready[grant_ch] = !fifo_full; all other s_ready bits are 0.
  - fifo_wr_en = s_valid[grant_ch] && !fifo_full (combinational).
  - fifo_wr_din is a combinational mux of the granted channel.
  - Each accepted beat increments beat_cnt.
  - Return to IDLE at the end of any cycle where any of these holds:
    - a beat is accepted and beat_cnt==P_BURST-1;
    - s_valid[grant_ch]=0;
    - fifo_almost_full=1.
  - If fifo_full=1 and s_valid is still high, stay in BURST and stall; no beat is accepted.
  - The exit conditions are OR'd. When several hold in the same cycle, a beat accepted in that cycle is still written.
- cfg_en_mask affects only arbitration in IDLE. Clearing a bit mid-burst does not abort the burst.
- Reset mid-burst: return to IDLE, with no further fifo_wr_en from the next cycle. Words already written stay in the FIFO, subject to the FIFO's own reset.
- No data storage is held in this block. Correctness relies on the FIFO gating writes by full; this block never asserts fifo_wr_en while fifo_full=1.

## Timing
- Arbitration latency: s_valid seen in IDLE at cycle n gives the grant at n+1, and the first beat can be accepted at n+1.
- Throughput: at most P_BURST beats per grant, followed by at least 1 IDLE cycle between grants. Peak efficiency is P_BURST/(P_BURST+1).
- fifo_full arriving in cycle n blocks acceptance in the same cycle n (combinational path from fifo_full to s_ready and fifo_wr_en).
- fifo_almost_full=1 ends the burst after the current cycle and blocks new grants until it deasserts.
- busy = (state==BURST), registered.
- grant_ch changes only on the IDLE→BURST transition.

## Test plan
- **Reset then single channel:** rst for 2 cycles, then s_valid=4'b0001 held, mask=4'hF, FIFO never full.
  - Response: 4-beat bursts on ch0 separated by 1 IDLE cycle.
  - Each fifo_wr_din = {2'd0, data}, with 8 beats in 10 cycles.
- **All four channels continuously valid, P_BURST=4:**
  - Grant order 0,1,2,3,0.
  - Each grant writes exactly 4 words tagged with the correct ID, and no word is lost or duplicated against per-channel scoreboards.
- **fifo_full asserted for 3 cycles mid-burst, after beat 2:**
  - s_ready and fifo_wr_en are 0 for exactly those 3 cycles.
  - Beats 3-4 complete afterwards, and the data order is preserved.
- **fifo_almost_full rises during beat 1:**
  - Beat 1 is written and the state returns to IDLE.
  - No grant is issued while almost_full=1; arbitration resumes on the cycle after it falls.
- **cfg_en_mask=4'b1010 with all valid:**
  - Only ch1 and ch3 are granted, alternating; s_ready[0] and s_ready[2] stay 0.
- **rst asserted during beat 2 of a ch2 burst:**
  - fifo_wr_en=0 and busy=0 on the next cycle, and last_ch returns to 3.
  - After release, the next grant goes to the lowest valid channel starting from ch0.
